aryth_op_sched: RTL and testbench



---
 rtl/aryth_pkg.sv | 25 ++
 rtl/aryth_divu16x8.sv | 47 ++++
 rtl/aryth_op_sched.sv | 174 +++++++++++++++++
 tb/tb_aryth_op_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aryth_pkg.sv
// Shared types and constants for the arithmetic op scheduler and its divider.
package aryth_pkg;

  localparam int         DIV_LAT     = 16;
  localparam logic [7:0] EXP_MOD_DEF = 8'd25;

  typedef enum logic [1:0] {OP_MOD, OP_GCD, OP_MODEXP, OP_ILL} op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_DIV_START, S_DIV_WAIT, S_STEP, S_RESP
  } state_e;

  // One restoring-division iteration: returns {rem[7:0], quot[15:0]}.
  function automatic logic [23:0] div_step(input logic [7:0]  r,
                                           input logic [15:0] q,
                                           input logic [7:0]  d);
    logic [8:0] sh;
    logic [8:0] tr;
    sh = {r, q[15]};
    tr = sh - {1'b0, d};
    if (sh >= {1'b0, d}) div_step = {tr[7:0], q[14:0], 1'b1};
    else                 div_step = {sh[7:0], q[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/aryth_divu16x8.sv
// Iterative 16/8 restoring divider, one quotient bit per cycle; done pulses DIV_LAT cycles after start.
module aryth_divu16x8
  import aryth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [7:0]  rem
);

  logic [7:0] d;
  logic [4:0] cnt;

  // The start edge already performs the first iteration so done lands DIV_LAT cycles after start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      quot <= '0;
      rem  <= '0;
      d    <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        {rem, quot} <= div_step(8'd0, dividend, divisor);
        d           <= divisor;
        cnt         <= 5'd1;
        busy        <= 1'b1;
      end else if (busy) begin
        {rem, quot} <= div_step(rem, quot, d);
        if (cnt == 5'(DIV_LAT - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/aryth_op_sched.sv
// Round-robin scheduler running MOD/GCD/MODEXP as chains of divisions on one shared divider.
// Optional ARYTH_OP_SCHED_PERF_EN adds saturating perf_ops/perf_busy counters.
module aryth_op_sched
  import aryth_pkg::*;
#(
  parameter logic [7:0] EXP_MOD = EXP_MOD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy
`ifdef ARYTH_OP_SCHED_PERF_EN
  ,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_busy
`endif
);

  state_e      state;
  op_e         op;
  logic        id, last, gnt;
  logic [7:0]  a, b, y;
  logic [2:0]  bit_idx;
  logic        mult_phase;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        div_done;
  logic [7:0]  div_rem;
  logic [15:0] unused_quot;
  logic        unused_div_busy;

  aryth_divu16x8 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == S_DIV_START),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (unused_div_busy),
    .done     (div_done),
    .quot     (unused_quot),
    .rem      (div_rem)
  );

  assign busy = (state != S_IDLE);

  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
    req_ready = '0;
    if (rst_n && state == S_IDLE && req_valid != 2'b00) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      op         <= OP_MOD;
      id         <= 1'b0;
      a          <= '0;
      b          <= '0;
      y          <= '0;
      bit_idx    <= '0;
      mult_phase <= 1'b0;
      dividend   <= '0;
      divisor    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|(req_valid & req_ready)) begin
          id    <= gnt;
          last  <= gnt;
          op    <= op_e'(gnt ? req1_op : req0_op);
          a     <= gnt ? req1_a : req0_a;
          b     <= gnt ? req1_b : req0_b;
          state <= S_DECODE;
        end
        S_DECODE: begin
          y          <= b;
          bit_idx    <= 3'd7;
          mult_phase <= 1'b0;
          dividend   <= {8'd0, a};
          divisor    <= b;
          state      <= S_DIV_START;
          rsp_id     <= id;
          if (op == OP_ILL || (op != OP_MODEXP && b == 8'd0)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= (op != OP_GCD);
            rsp_data  <= (op == OP_GCD) ? a : 8'd0;
            state     <= S_RESP;
          end else if (op == OP_MODEXP) begin
            dividend <= 16'd1;
            divisor  <= EXP_MOD;
          end
        end
        S_DIV_START: state <= S_DIV_WAIT;
        S_DIV_WAIT: if (div_done) begin
          if (op == OP_MOD) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= div_rem;
            state     <= S_RESP;
          end else begin
            state <= S_STEP;
          end
        end
        // The divider holds rem after done, so STEP reads it directly.
        S_STEP: begin
          state <= S_DIV_START;
          if (op == OP_GCD) begin
            if (div_rem == 8'd0) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= y;
              state     <= S_RESP;
            end else begin
              y        <= div_rem;
              dividend <= {8'd0, y};
              divisor  <= div_rem;
            end
          end else if (!mult_phase && b[bit_idx]) begin
            mult_phase <= 1'b1;
            dividend   <= {8'd0, div_rem} * {8'd0, a};
          end else if (bit_idx == 3'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= div_rem;
            state     <= S_RESP;
          end else begin
            bit_idx    <= bit_idx - 3'd1;
            mult_phase <= 1'b0;
            dividend   <= {8'd0, div_rem} * {8'd0, div_rem};
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARYTH_OP_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && perf_ops != '1) perf_ops <= perf_ops + 16'd1;
      if (busy && perf_busy != '1) perf_busy <= perf_busy + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aryth_op_sched.sv
// Directed self-checking bench for aryth_op_sched (hand-computed expectations, M=25).
module tb_aryth_op_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
`ifdef ARYTH_OP_SCHED_PERF_EN
  logic [15:0] perf_ops, perf_busy;
  int          xfers = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  aryth_op_sched #(.EXP_MOD(8'd25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef ARYTH_OP_SCHED_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_busy (perf_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ARYTH_OP_SCHED_PERF_EN
  always @(posedge clk) begin
    if (!rst_n) xfers <= 0;
    else if (rsp_valid && rsp_ready) xfers <= xfers + 1;
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1);
  end

  // Drive a command and hold valid until accepted; t = accept cycle or -1.
  task automatic send(input logic r, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, output int t);
    t = -1;
    @(negedge clk);
    if (r == 1'b0) begin req0_op = op; req0_a = a; req0_b = b; end
    else           begin req1_op = op; req1_a = a; req1_b = b; end
    req_valid[r] = 1'b1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      #1;
      if (req_ready[r]) t = cyc;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  // Send, wait for the response (rsp_ready assumed high); lat = accept-to-rsp_valid cycles.
  task automatic run(input logic r, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, output int lat, output logic [7:0] d,
                     output logic id, output logic e);
    int t, tr;
    send(r, op, a, b, t);
    tr = -1;
    for (int i = 0; i < 400 && tr < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) tr = cyc;
    end
    lat = (t < 0 || tr < 0) ? -1 : tr - t;
    d = rsp_data;
    id = rsp_id;
    e = rsp_err;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data, busy, req_ready} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, need 0", {rsp_valid, rsp_id, rsp_err, rsp_data, busy, req_ready});
    end
  endtask

  task automatic test_mod;
    int t, tr, busy_low;
    send(1'b0, 2'd0, 8'd200, 8'd7, t);
    tr = -1;
    busy_low = 0;
    for (int i = 0; i < 60 && tr < 0; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (rsp_valid) tr = cyc;
    end
    n_checks++;
    if (t < 0 || tr < 0 || tr - t != 19) begin
      n_fail++; $display("FAIL mod_latency: got %0d, need 19", (t < 0 || tr < 0) ? -1 : tr - t);
    end
    n_checks++;
    if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 8'd4}) begin
      n_fail++; $display("FAIL mod_200_7: got id=%0d err=%0d data=%0d, need id=0 err=0 data=4", rsp_id, rsp_err, rsp_data);
    end
    n_checks++;
    if (busy_low != 0) begin
      n_fail++; $display("FAIL mod_busy: busy low in %0d cycles, need 0", busy_low);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL mod_idle_after: got busy/valid=%b, need 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_gcd;
    int lat; logic [7:0] d; logic id, e;
    run(1'b1, 2'd1, 8'd12, 8'd18, lat, d, id, e);
    n_checks++;
    if (lat < 0 || {id, e, d} !== {1'b1, 1'b0, 8'd6}) begin
      n_fail++; $display("FAIL gcd_12_18: got lat=%0d id=%0d err=%0d data=%0d, need id=1 err=0 data=6", lat, id, e, d);
    end
    run(1'b0, 2'd1, 8'd0, 8'd0, lat, d, id, e);
    n_checks++;
    if ({lat, id, e, d} !== {32'd2, 1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL gcd_0_0: got lat=%0d err=%0d data=%0d, need lat=2 err=0 data=0", lat, e, d);
    end
    run(1'b0, 2'd1, 8'd9, 8'd0, lat, d, id, e);
    n_checks++;
    if ({lat, e, d} !== {32'd2, 1'b0, 8'd9}) begin
      n_fail++; $display("FAIL gcd_9_0: got lat=%0d err=%0d data=%0d, need lat=2 err=0 data=9", lat, e, d);
    end
  endtask

  task automatic test_modexp;
    int lat; logic [7:0] d; logic id, e;
    logic [7:0] va [4] = '{8'd3, 8'd7, 8'd255, 8'd2};
    logic [7:0] vb [4] = '{8'd4, 8'd0, 8'd255, 8'd10};
    logic [7:0] ve [4] = '{8'd6, 8'd1, 8'd0,   8'd24};
    for (int k = 0; k < 4; k++) begin
      run(1'(k), 2'd2, va[k], vb[k], lat, d, id, e);
      n_checks++;
      if (lat < 0 || {id, e, d} !== {1'(k), 1'b0, ve[k]}) begin
        n_fail++;
        $display("FAIL modexp_%0d_%0d: got lat=%0d id=%0d err=%0d data=%0d, need err=0 data=%0d",
                 va[k], vb[k], lat, id, e, d, ve[k]);
      end
    end
  endtask

  task automatic test_errors;
    int lat; logic [7:0] d; logic id, e;
    run(1'b1, 2'd3, 8'd5, 8'd5, lat, d, id, e);
    n_checks++;
    if ({lat, id, e, d} !== {32'd2, 1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL illegal_op: got lat=%0d id=%0d err=%0d data=%0d, need lat=2 id=1 err=1 data=0", lat, id, e, d);
    end
    run(1'b0, 2'd0, 8'd9, 8'd0, lat, d, id, e);
    n_checks++;
    if ({lat, id, e, d} !== {32'd2, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL mod_div0: got lat=%0d id=%0d err=%0d data=%0d, need lat=2 id=0 err=1 data=0", lat, id, e, d);
    end
  endtask

  task automatic test_arbitration;
    int lat, k; logic [7:0] d; logic id, e;
    logic [1:0] need;
    run(1'b1, 2'd3, 8'd0, 8'd0, lat, d, id, e);
    @(negedge clk);
    req0_op = 2'd3; req1_op = 2'd3;
    req_valid = 2'b11;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        need = (k % 2 == 1) ? 2'b10 : 2'b01;
        n_checks++;
        if (req_ready !== need) begin
          n_fail++; $display("FAIL rr_grant_%0d: got req_ready=%b, need %b", k, req_ready, need);
        end
        k++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_checks++;
    if (k != 4) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d grants, need 4", k);
    end
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int t, tr, lat, bad;
    rsp_ready = 1'b0;
    send(1'b0, 2'd0, 8'd100, 8'd9, t);
    tr = -1;
    for (int i = 0; i < 60 && tr < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) tr = cyc;
    end
    req1_op = 2'd1; req1_a = 8'd9; req1_b = 8'd0;
    req_valid[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready} !== {1'b1, 1'b0, 1'b0, 8'd1, 2'b00}) bad++;
      if (i == 9) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (tr < 0 || bad != 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles (rsp seen=%0d), need 0", bad, tr >= 0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 3'b010) begin
      n_fail++; $display("FAIL bp_next_accept: got valid/ready=%b, need 010", {rsp_valid, req_ready});
    end
    t = cyc;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    tr = -1;
    for (int i = 0; i < 10 && tr < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) tr = cyc;
    end
    lat = (tr < 0) ? -1 : tr - t;
    n_checks++;
    if ({lat, rsp_id, rsp_err, rsp_data} !== {32'd2, 1'b1, 1'b0, 8'd9}) begin
      n_fail++; $display("FAIL bp_after_release: got lat=%0d id=%0d data=%0d, need lat=2 id=1 data=9", lat, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_mid;
    int t, lat, stale; logic [7:0] d; logic id, e;
    send(1'b0, 2'd1, 8'd12, 8'd18, t);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_data, busy, req_ready} !== 13'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b, need 0", {rsp_valid, rsp_id, rsp_err, rsp_data, busy, req_ready});
    end
`ifdef ARYTH_OP_SCHED_PERF_EN
    n_checks++;
    if ({perf_ops, perf_busy} !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got ops=%0d busy=%0d, need 0", perf_ops, perf_busy);
    end
`endif
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++; $display("FAIL reset_mid_stale: got %0d active cycles, need 0", stale);
    end
    run(1'b0, 2'd0, 8'd200, 8'd7, lat, d, id, e);
    n_checks++;
    if ({lat, id, e, d} !== {32'd19, 1'b0, 1'b0, 8'd4}) begin
      n_fail++; $display("FAIL reset_mid_mod: got lat=%0d err=%0d data=%0d, need lat=19 err=0 data=4", lat, e, d);
    end
  endtask

`ifdef ARYTH_OP_SCHED_PERF_EN
  task automatic test_perf;
    repeat (2) @(negedge clk);
    n_checks++;
    if (perf_ops !== 16'(xfers) || xfers != 1) begin
      n_fail++; $display("FAIL perf_ops: got %0d, need %0d (expected 1)", perf_ops, xfers);
    end
  endtask
`endif

  initial begin
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    test_reset;
    req_valid = 2'b00;
    rst_n = 1'b1;
    test_mod;
    test_gcd;
    test_modexp;
    test_errors;
    test_arbitration;
    test_backpressure;
    test_reset_mid;
`ifdef ARYTH_OP_SCHED_PERF_EN
    test_perf;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
